// File: rtl/tlc_pkg.sv
// Shared encodings for the demand-actuated phase scheduler: light codes,
// phase codes, FSM states and the phase-to-green mask.
package tlc_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam logic [1:0] PH_MAIN = 2'd0;
  localparam logic [1:0] PH_TURN = 2'd1;
  localparam logic [1:0] PH_SIDE = 2'd2;
  localparam logic [1:0] PH_PED  = 2'd3;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  // One nibble per phase (PED, SIDE, TURN, MAIN); nibble bit order M1, MT, M2, S.
  localparam logic [15:0] GREEN_MASK = {4'b0000, 4'b0001, 4'b1100, 4'b1010};

  function automatic logic [3:0] green_mask(input logic [1:0] ph);
    return GREEN_MASK[4*ph +: 4];
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Round-robin selector: finds the first pending phase after cur_phase and
// reports whether any phase other than cur_phase is pending.
module tlc_rr_pick #(
  parameter int NUM_PH = 3
) (
  input  logic [3:0] pending,
  input  logic [1:0] cur_phase,
  output logic [1:0] nxt_phase,
  output logic       other
);

  logic [1:0] idx;

  // Scan farthest to nearest so the nearest pending phase is the last write.
  always_comb begin
    nxt_phase = cur_phase;
    other     = 1'b0;
    idx       = '0;
    for (int i = NUM_PH - 1; i >= 1; i--) begin
      idx = 2'((32'(cur_phase) + i) % NUM_PH);
      if (pending[idx]) begin
        nxt_phase = idx;
        other     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-actuated junction phase scheduler with min/max green, yellow and
// all-red clearance. Define TLC_PED_EN to add the pedestrian phase.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int PED_T     = 6,
  parameter int TW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_M1,
  input  logic          req_M2,
  input  logic          req_MT,
  input  logic          req_S,
`ifdef TLC_PED_EN
  input  logic          ped_req,
  output logic          ped_walk,
`endif
  output logic [2:0]    light_M1,
  output logic [2:0]    light_MT,
  output logic [2:0]    light_M2,
  output logic [2:0]    light_S,
  output logic [1:0]    phase,
  output logic [TW-1:0] count
);

`ifdef TLC_PED_EN
  localparam int NUM_PH = 4;
  localparam logic [TW-1:0] PED_LAST = TW'(PED_T - 1);
`else
  localparam int NUM_PH = 3;
`endif
  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] AR_LAST  = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] TIM_MAX  = '1;

  if (MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN || YELLOW_T < 1 || ALLRED_T < 1 ||
      MAX_GREEN >= (1 << TW) || YELLOW_T >= (1 << TW) ||
      ALLRED_T >= (1 << TW) || PED_T >= (1 << TW)) begin : g_bad_params
    $error("tlc_phase_scheduler: timing parameter out of range");
  end

  state_t        state_reg, state_next;
  logic [1:0]    cur_reg, cur_next;
  logic [1:0]    nxt_reg, nxt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [3:0]    pend_reg, pend_next;
  logic [3:0]    demand;
  logic [3:0]    cur_onehot;
  logic [1:0]    pick_phase;
  logic          pick_other;
  logic          green_exit;

`ifdef TLC_PED_EN
  assign demand = {ped_req, req_S, req_MT, req_M1 | req_M2};
`else
  assign demand = {1'b0, req_S, req_MT, req_M1 | req_M2};
`endif
  assign cur_onehot = 4'b0001 << cur_reg;

  tlc_rr_pick #(.NUM_PH(NUM_PH)) u_pick (
    .pending   (pend_reg),
    .cur_phase (cur_reg),
    .nxt_phase (pick_phase),
    .other     (pick_other)
  );

  always_comb begin
    state_next = state_reg;
    cur_next   = cur_reg;
    nxt_next   = nxt_reg;
    timer_next = (timer_reg == TIM_MAX) ? timer_reg : timer_reg + 1'b1;
    pend_next  = pend_reg | demand;
    green_exit = 1'b0;
    unique case (state_reg)
      ST_GREEN: begin
        // The phase being served does not re-queue itself.
        pend_next = pend_reg | (demand & ~cur_onehot);
`ifdef TLC_PED_EN
        if (cur_reg == PH_PED) begin
          green_exit = (timer_reg >= PED_LAST);
        end else
`endif
        begin
          green_exit = pick_other &&
                       ((timer_reg >= MIN_LAST && !demand[cur_reg]) || timer_reg >= MAX_LAST);
          timer_next = (timer_reg >= MAX_LAST) ? MAX_LAST : timer_reg + 1'b1;
        end
        if (green_exit) begin
          state_next = ST_YELLOW;
          timer_next = '0;
          nxt_next   = pick_other ? pick_phase : PH_MAIN;
        end
      end
      ST_YELLOW: begin
        if (timer_reg == YEL_LAST) begin
          state_next = ST_ALLRED;
          timer_next = '0;
        end
      end
      ST_ALLRED: begin
        if (timer_reg == AR_LAST) begin
          state_next         = ST_GREEN;
          timer_next         = '0;
          cur_next           = nxt_reg;
          pend_next[nxt_reg] = 1'b0;
        end
      end
      default: begin
        state_next = ST_ALLRED;
        timer_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_ALLRED;
      cur_reg   <= PH_MAIN;
      nxt_reg   <= PH_MAIN;
      timer_reg <= '0;
      pend_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cur_reg   <= cur_next;
      nxt_reg   <= nxt_next;
      timer_reg <= timer_next;
      pend_reg  <= pend_next;
    end
  end

  // Overlap only exists across a real phase change; after reset cur == nxt and all is red.
  logic [3:0]       cur_mask, nxt_mask, keep_mask;
  logic [3:0][2:0]  lights;

  assign cur_mask  = green_mask(cur_reg);
  assign nxt_mask  = green_mask(nxt_reg);
  assign keep_mask = (cur_reg != nxt_reg) ? (cur_mask & nxt_mask) : 4'b0000;

  for (genvar gi = 0; gi < 4; gi++) begin : g_light
    assign lights[gi] =
      ((state_reg == ST_GREEN && cur_mask[gi]) ||
       (state_reg != ST_GREEN && keep_mask[gi])) ? LIGHT_GRN :
      (state_reg == ST_YELLOW && cur_mask[gi])   ? LIGHT_YEL : LIGHT_RED;
  end

  assign light_M1 = lights[3];
  assign light_MT = lights[2];
  assign light_M2 = lights[1];
  assign light_S  = lights[0];
  assign phase    = cur_reg;
  assign count    = timer_reg;
`ifdef TLC_PED_EN
  assign ped_walk = (state_reg == ST_GREEN) && (cur_reg == PH_PED);
`endif

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Bench for tlc_phase_scheduler (default three-phase build): a segment-level
// model checked every cycle, plus literal expectations along a directed scenario.
module tb_tlc_phase_scheduler;

  localparam int MIN_G = 4;
  localparam int MAX_G = 12;
  localparam int YEL   = 2;
  localparam int AR    = 1;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_M1 = 1'b0, req_M2 = 1'b0, req_MT = 1'b0, req_S = 1'b0;
  logic [2:0] light_M1, light_MT, light_M2, light_S;
  logic [1:0] phase;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tlc_phase_scheduler dut (
    .clk      (clk),
    .rst      (rst),
    .req_M1   (req_M1),
    .req_M2   (req_M2),
    .req_MT   (req_MT),
    .req_S    (req_S),
    .light_M1 (light_M1),
    .light_MT (light_MT),
    .light_M2 (light_M2),
    .light_S  (light_S),
    .phase    (phase),
    .count    (count)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the junction is either in a green segment or in a change interval of
  // YEL+AR cycles (first YEL show yellow). Greens per phase, bits M1,MT,M2,S.
  bit         m_valid = 0;
  bit         m_green;
  int         m_t, m_cur, m_nxt;
  bit [3:0]   m_pend;
  bit [3:0]   gm [3] = '{4'b1010, 4'b1100, 4'b0001};

  task automatic model_step();
    bit [3:0] d, np;
    bit       other, found;
    if (rst) begin
      m_valid = 1; m_green = 0; m_t = YEL; m_cur = 0; m_nxt = 0; m_pend = '0;
    end else if (m_valid) begin
      d  = {1'b0, req_S, req_MT, req_M1 | req_M2};
      np = m_pend | d;
      if (m_green) begin
        np[m_cur] = m_pend[m_cur];
        other = 0;
        for (int p = 0; p < 3; p++) if (p != m_cur && m_pend[p]) other = 1;
        if (other && ((m_t >= MIN_G - 1 && !d[m_cur]) || m_t >= MAX_G - 1)) begin
          found = 0;
          for (int k = 1; k < 3; k++) begin
            if (!found && m_pend[(m_cur + k) % 3]) begin
              m_nxt = (m_cur + k) % 3;
              found = 1;
            end
          end
          m_green = 0;
          m_t = 0;
        end else begin
          m_t = (m_t + 1 > MAX_G - 1) ? MAX_G - 1 : m_t + 1;
        end
      end else if (m_t == YEL + AR - 1) begin
        m_green = 1;
        m_t = 0;
        m_cur = m_nxt;
        np[m_cur] = 1'b0;
      end else begin
        m_t++;
      end
      m_pend = np;
    end
  endtask

  function automatic logic [2:0] m_light(input int k);
    bit cg = gm[m_cur][k];
    bit ng = gm[m_nxt][k];
    if (m_green) return cg ? G : R;
    if (m_cur != m_nxt && cg && ng) return G;
    if (m_t < YEL && cg) return Y;
    return R;
  endfunction

  function automatic int m_count();
    if (m_green || m_t < YEL) return m_t;
    return m_t - YEL;
  endfunction

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("model_M1", 8'(light_M1), 8'(m_light(3)));
      check("model_MT", 8'(light_MT), 8'(m_light(2)));
      check("model_M2", 8'(light_M2), 8'(m_light(1)));
      check("model_S", 8'(light_S), 8'(m_light(0)));
      check("model_phase", 8'(phase), 8'(m_cur));
      check("model_count", 8'(count), 8'(m_count()));
    end
  end

  task automatic wait_green(input string name, input int ph);
    int  i = 0;
    bit  ok = 0;
    while (!ok && i < 40) begin
      ok = (phase == 2'(ph)) &&
           ((ph == 0 && light_M1 == G) || (ph == 1 && light_MT == G) || (ph == 2 && light_S == G));
      if (!ok) begin
        @(negedge clk);
        i++;
      end
    end
    check(name, 8'(ok), 8'd1);
  endtask

  task automatic lights4(input string name, input logic [2:0] m1, input logic [2:0] mt,
                         input logic [2:0] m2, input logic [2:0] s);
    check({name, "_M1"}, 8'(light_M1), 8'(m1));
    check({name, "_MT"}, 8'(light_MT), 8'(mt));
    check({name, "_M2"}, 8'(light_M2), 8'(m2));
    check({name, "_S"}, 8'(light_S), 8'(s));
  endtask

  initial begin
    int len;
    int i;

    // Reset held two cycles, then one cycle of all-red before MAIN green.
    repeat (2) @(negedge clk);
    lights4("rst", R, R, R, R);
    check("rst_count", 8'(count), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    lights4("rel", G, R, G, R);
    check("rel_phase", 8'(phase), 8'd0);

    // Idle: MAIN rests, timer saturates at MAX_G-1.
    repeat (40) @(negedge clk);
    check("idle_count", 8'(count), 8'd11);
    check("idle_phase", 8'(phase), 8'd0);

    // Gap-out: fresh MAIN green, req_S pulse at count 1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("gap_c0", 8'(count), 8'd0);
    @(negedge clk);
    req_S = 1'b1;
    @(negedge clk);
    req_S = 1'b0;
    @(negedge clk);
    check("gap_c3", 8'(count), 8'd3);
    lights4("gap_g3", G, R, G, R);
    @(negedge clk);
    lights4("gap_y0", Y, R, Y, R);
    @(negedge clk);
    lights4("gap_y1", Y, R, Y, R);
    @(negedge clk);
    lights4("gap_ar", R, R, R, R);
    @(negedge clk);
    lights4("gap_side", R, R, R, G);
    check("gap_phase", 8'(phase), 8'd2);

    // Max-out: MAIN demand held, SIDE pending from the first green cycle.
    req_M1 = 1'b1;
    wait_green("max_wait", 0);
    len = 0;
    req_S = 1'b1;
    while (light_M1 == G && len < 40) begin
      len++;
      @(negedge clk);
      if (len == 1) req_S = 1'b0;
    end
    check("max_len", 8'(len), 8'd12);
    check("max_yel", 8'(light_M1), 8'(Y));
    req_M1 = 1'b0;
    wait_green("max_side", 2);

    // Overlap and round-robin: TURN before SIDE, M1 held green across the change.
    req_M1 = 1'b1;
    @(negedge clk);
    req_M1 = 1'b0;
    wait_green("ov_main", 0);
    req_MT = 1'b1;
    req_S  = 1'b1;
    @(negedge clk);
    req_MT = 1'b0;
    req_S  = 1'b0;
    i = 0;
    while (light_M2 != Y && i < 20) begin
      @(negedge clk);
      i++;
    end
    lights4("ov_y", G, R, Y, R);
    repeat (2) @(negedge clk);
    lights4("ov_ar", G, R, R, R);
    @(negedge clk);
    lights4("ov_turn", G, G, R, R);
    check("ov_turn_ph", 8'(phase), 8'd1);
    wait_green("ov_side", 2);

    // Reset during yellow with SIDE re-requested: pending demand is dropped.
    req_M1 = 1'b1;
    @(negedge clk);
    req_M1 = 1'b0;
    i = 0;
    while (light_S != Y && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("mid_yel", 8'(light_S), 8'(Y));
    req_S = 1'b1;
    @(negedge clk);
    req_S = 1'b0;
    rst   = 1'b1;
    @(negedge clk);
    lights4("mid_rst", R, R, R, R);
    check("mid_rst_ph", 8'(phase), 8'd0);
    check("mid_rst_cnt", 8'(count), 8'd0);
    rst = 1'b0;
    @(negedge clk);
    lights4("mid_rel", G, R, G, R);
    repeat (20) @(negedge clk);
    check("mid_nosvc_ph", 8'(phase), 8'd0);
    lights4("mid_nosvc", G, R, G, R);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
